// File: rtl/mmap_apb_guard_pkg.sv
// Shared types and constants for the mmap -> APB guard stage.
//   guard_state_e        : FSM encoding (IDLE, REQ, RESP, ABORT)
//   MMAP_GUARD_ERR_RDATA : default read data returned on a timed-out access
//   ERR_CNT_W            : width of the saturating timeout counter output
package mmap_apb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } guard_state_e;

  localparam logic [31:0] MMAP_GUARD_ERR_RDATA = 32'hDEAD_BEEF;
  localparam int          ERR_CNT_W            = 8;

endpackage

// File: rtl/mmap_apb_guard.sv
// Registered guard between the core's native mmap master port and the APB
// wrapper's mmap slave port. Each upstream request is latched and issued
// downstream; the response is registered and returned as a one-cycle pulse.
// A downstream access that never completes is aborted after a bounded wait,
// answered with ERR_RDATA, and recorded in the error registers.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   s_mmap_*              : upstream slave side (valid/addr/wdata/wstrb in,
//                           rdata/ready out; ready is a completion pulse)
//   m_mmap_*              : downstream master side (registered request out,
//                           rdata/ready in)
//   err_clr_i             : clears the sticky interrupt
//   err_irq_o             : sticky timeout interrupt
//   err_addr_o, err_wr_o  : address / direction of the latest timed-out access
//   err_cnt_o             : saturating count of timeouts
module mmap_apb_guard
  import mmap_apb_guard_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          CNT_W          = 16,
  parameter logic [31:0] ERR_RDATA      = MMAP_GUARD_ERR_RDATA
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_mmap_valid_i,
  input  logic [31:0]          s_mmap_addr_i,
  input  logic [31:0]          s_mmap_wdata_i,
  input  logic [3:0]           s_mmap_wstrb_i,
  output logic [31:0]          s_mmap_rdata_o,
  output logic                 s_mmap_ready_o,
  output logic                 m_mmap_valid_o,
  output logic [31:0]          m_mmap_addr_o,
  output logic [31:0]          m_mmap_wdata_o,
  output logic [3:0]           m_mmap_wstrb_o,
  input  logic [31:0]          m_mmap_rdata_i,
  input  logic                 m_mmap_ready_i,
  input  logic                 err_clr_i,
  output logic                 err_irq_o,
  output logic [31:0]          err_addr_o,
  output logic                 err_wr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  // The first REQ cycle issues the access; TIMEOUT_CYCLES further cycles of
  // waiting are allowed before giving up, so the abort fires when the wait
  // counter (0 in the first REQ cycle) reaches TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES);

  guard_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          addr_p0;
  logic [31:0]          wdata_p0;
  logic [3:0]           wstrb_p0;
  logic [31:0]          rdata_p1;
  logic                 err_irq_q;
  logic [31:0]          err_addr_q;
  logic                 err_wr_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (s_mmap_valid_i) state_d = REQ;
      REQ: begin
        // A ready arriving in the timeout cycle still completes normally.
        if (m_mmap_ready_i)
          state_d = RESP;
        else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST))
          state_d = ABORT;
      end
      RESP:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      wstrb_p0   <= '0;
      rdata_p1   <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
      err_wr_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // Stage p0: request capture
        IDLE: begin
          cnt_q <= '0;
          if (s_mmap_valid_i) begin
            addr_p0  <= s_mmap_addr_i;
            wdata_p0 <= s_mmap_wdata_i;
            wstrb_p0 <= s_mmap_wstrb_i;
          end
        end
        // Stage p1: response capture (writes pass rdata through unchanged)
        REQ: begin
          cnt_q <= cnt_sat_inc(cnt_q);
          if (m_mmap_ready_i) rdata_p1 <= m_mmap_rdata_i;
        end
        ABORT: begin
          err_addr_q <= addr_p0;
          err_wr_q   <= |wstrb_p0;
          err_cnt_q  <= err_sat_inc(err_cnt_q);
        end
        default: ;
      endcase
      // A new abort outranks a simultaneous clear request.
      if (state_q == ABORT)
        err_irq_q <= 1'b1;
      else if (err_clr_i)
        err_irq_q <= 1'b0;
    end
  end

  assign m_mmap_valid_o = (state_q == REQ);
  assign m_mmap_addr_o  = addr_p0;
  assign m_mmap_wdata_o = wdata_p0;
  assign m_mmap_wstrb_o = wstrb_p0;
  assign s_mmap_ready_o = (state_q == RESP) || (state_q == ABORT);
  assign s_mmap_rdata_o = (state_q == ABORT) ? ERR_RDATA :
                          (state_q == RESP)  ? rdata_p1  : '0;
  assign err_irq_o      = err_irq_q;
  assign err_addr_o     = err_addr_q;
  assign err_wr_o       = err_wr_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_mmap_apb_guard.sv
// Self-checking bench for mmap_apb_guard (TIMEOUT_CYCLES = 8).
// Expected upstream responses are queued when a request is issued and
// compared by a monitor whenever s_mmap_ready_o pulses.
module tb_mmap_apb_guard;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err_clr;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_wr;
  logic [7:0]  err_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  mmap_apb_guard #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_mmap_valid_i (s_valid),
    .s_mmap_addr_i  (s_addr),
    .s_mmap_wdata_i (s_wdata),
    .s_mmap_wstrb_i (s_wstrb),
    .s_mmap_rdata_o (s_rdata),
    .s_mmap_ready_o (s_ready),
    .m_mmap_valid_o (m_valid),
    .m_mmap_addr_o  (m_addr),
    .m_mmap_wdata_o (m_wdata),
    .m_mmap_wstrb_o (m_wstrb),
    .m_mmap_rdata_i (m_rdata),
    .m_mmap_ready_i (m_ready),
    .err_clr_i      (err_clr),
    .err_irq_o      (err_irq),
    .err_addr_o     (err_addr),
    .err_wr_o       (err_wr),
    .err_cnt_o      (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every upstream pulse must match the oldest queued response.
  always @(negedge clk) begin
    if (s_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse rdata=%h required=no pulse", s_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (s_rdata !== mon_exp) begin
          failures++;
          $display("FAIL resp_rdata got=%h exp=%h", s_rdata, mon_exp);
        end
      end
    end
  end

  // One full upstream access. dly = cycles after the m_valid rise at which
  // downstream ready is given (-1 = never). Returns at the negedge one cycle
  // after the upstream pulse.
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input int dly,
                            input logic [31:0] rd, input bit clr_at_pulse,
                            output int lat);
    bit to;
    bit seen;
    int n;
    int exp_lat;
    to = (dly < 0) || (dly > T);
    exp_lat = to ? T + 1 : dly + 1;
    exp_q.push_back(to ? ERR : rd);
    s_valid = 1'b1; s_addr = a; s_wdata = wd; s_wstrb = ws;
    n = 0; seen = 1'b0;
    while (!seen && n < 4) begin
      @(negedge clk);
      n++;
      if (m_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 1) begin
      failures++;
      $display("FAIL mvalid_rise cycles=%0d seen=%0d exp_cycles=1", n, seen);
    end
    checks++;
    if ({m_addr, m_wdata, m_wstrb} !== {a, wd, ws}) begin
      failures++;
      $display("FAIL m_request got=%h/%h/%h exp=%h/%h/%h", m_addr, m_wdata, m_wstrb, a, wd, ws);
    end
    lat = -1;
    for (int j = 0; j < T + 12; j++) begin
      if (j > 0) @(negedge clk);
      if (s_ready) begin
        lat = j;
        break;
      end
      m_ready = (j == dly);
      m_rdata = rd;
    end
    m_ready = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL resp_latency got=%0d exp=%0d", lat, exp_lat);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL mvalid_drop got=%b exp=0", m_valid);
    end
    s_valid = 1'b0;
    err_clr = clr_at_pulse;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_one_cycle got=%b exp=0", s_ready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({s_ready, m_valid, err_irq, err_wr} !== 4'b0 || s_rdata !== 32'h0) begin
      failures++;
      $display("FAIL %s_ctrl ready=%b mvalid=%b irq=%b wr=%b rdata=%h exp=0", tag, s_ready, m_valid, err_irq, err_wr, s_rdata);
    end
    checks++;
    if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin
      failures++;
      $display("FAIL %s_mreq got=%h/%h/%h exp=0", tag, m_addr, m_wdata, m_wstrb);
    end
    checks++;
    if (err_addr !== 32'h0 || err_cnt !== 8'h0) begin
      failures++;
      $display("FAIL %s_err addr=%h cnt=%0d exp=0", tag, err_addr, err_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat;
    run_access(32'h0300_1000, 32'h0, 4'h0, 4, 32'h1234_5678, 1'b0, lat);
    checks++;
    if (err_irq !== 1'b0) begin
      failures++;
      $display("FAIL read_irq got=%b exp=0", err_irq);
    end
  endtask

  task automatic test_write();
    int lat;
    run_access(32'h0300_2004, 32'hA5A5_0001, 4'hF, 0, 32'h0BAD_F00D, 1'b0, lat);
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL write_errcnt got=%0d exp=0", err_cnt);
    end
  endtask

  task automatic test_ready_at_timeout_cycle();
    int lat;
    run_access(32'h0300_3000, 32'h0, 4'h0, T, 32'h7777_0000, 1'b0, lat);
    checks++;
    if (err_cnt !== 8'd0 || err_irq !== 1'b0) begin
      failures++;
      $display("FAIL edge_ready_err cnt=%0d irq=%b exp=0/0", err_cnt, err_irq);
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit pulse;
    run_access(32'h0300_5000, 32'h0, 4'h0, -1, 32'h1111_2222, 1'b0, lat);
    checks++;
    if (err_addr !== 32'h0300_5000 || err_wr !== 1'b0) begin
      failures++;
      $display("FAIL tmo_capture addr=%h wr=%b exp=03005000/0", err_addr, err_wr);
    end
    checks++;
    if (err_irq !== 1'b1 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL tmo_err irq=%b cnt=%0d exp=1/1", err_irq, err_cnt);
    end
    // Late downstream ready 3 cycles after the abort pulse must be ignored.
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h5555_AAAA;
    @(negedge clk);
    m_ready = 1'b0;
    pulse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s_ready) pulse = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (pulse !== 1'b0) begin
      failures++;
      $display("FAIL late_ready_pulse got=%b exp=0", pulse);
    end
  endtask

  task automatic test_err_clr();
    int lat;
    run_access(32'h0300_6008, 32'hCAFE_0002, 4'h3, -1, 32'h0, 1'b1, lat);
    checks++;
    if (err_irq !== 1'b1 || err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL clr_vs_abort irq=%b cnt=%0d exp=1/2", err_irq, err_cnt);
    end
    checks++;
    if (err_addr !== 32'h0300_6008 || err_wr !== 1'b1) begin
      failures++;
      $display("FAIL clr_capture addr=%h wr=%b exp=03006008/1", err_addr, err_wr);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_irq !== 1'b0 || err_cnt !== 8'd2 || err_addr !== 32'h0300_6008) begin
      failures++;
      $display("FAIL clr_alone irq=%b cnt=%0d addr=%h exp=0/2/03006008", err_irq, err_cnt, err_addr);
    end
  endtask

  task automatic test_saturate();
    int lat;
    for (int i = 0; i < 256; i++)
      run_access(32'h0400_0000 + 32'(i * 4), 32'h0, 4'h0, -1, 32'h0, 1'b0, lat);
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL errcnt_saturate got=%0d exp=255", err_cnt);
    end
    checks++;
    if (err_addr !== 32'h0400_03FC) begin
      failures++;
      $display("FAIL sat_last_addr got=%h exp=040003fc", err_addr);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    s_valid = 1'b1; s_addr = 32'h0300_7000; s_wdata = 32'h0; s_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_inreq mvalid=%b exp=1", m_valid);
    end
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_queue got=%0d exp=0", exp_q.size());
    end
    run_access(32'h0300_8000, 32'h0, 4'h0, 2, 32'h600D_600D, 1'b0, lat);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_rdata = '0; m_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_ready_at_timeout_cycle();
    test_timeout();
    test_err_clr();
    test_saturate();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
